// File: rtl/ddr4_phy_pkg.sv
// Shared types and constants for the DDR4 command/address lane transmit control.
//   adj_cmd_e   : encoding of the delay-line adjust command
//   adj_state_e : adjust engine states
//   CS_N_IDLE   : command phases that keep the chip deselected
package ddr4_phy_pkg;

  typedef enum logic [1:0] {
    ADJ_LOAD = 2'b00,
    ADJ_INC  = 2'b01,
    ADJ_DEC  = 2'b10,
    ADJ_RSV  = 2'b11
  } adj_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_GAP,
    S_DONE
  } adj_state_e;

  localparam logic [3:0] CS_N_IDLE = 4'hF;

endpackage

// File: rtl/ddr4_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : synchronous reset, active high, clears both stages
//   d_i   : asynchronous input level
//   q_o   : synchronized level, two cycles of latency
module ddr4_bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ddr4_ca_lane_tx_ctrl.sv
// Fabric-side driver for one DDR4 command/address output lane.
// Registers the 4-phase command data and output enable into the lane IOD and runs
// a request/ack delay-line adjust engine (LOAD, or N-step INC/DEC with settle gaps).
//   FAB_CLK, TX_SYNC_RST           : clock, synchronous active-high reset
//   DFI_CS_N, OUT_EN               : command phases and driver enable in
//   ADJ_REQ, ADJ_CMD, ADJ_COUNT    : adjust request interface
//   ADJ_BUSY, ADJ_ACK, ADJ_ERR     : adjust status
//   TAP_VALUE                      : tracked delay-line tap
//   TX_DATA_0, OE_DATA_0           : to IOD data/enable
//   DELAY_LINE_LOAD/MOVE/DIRECTION : to IOD delay-line control
//   DELAY_LINE_OUT_OF_RANGE_0      : from IOD, asynchronous
module ddr4_ca_lane_tx_ctrl
  import ddr4_phy_pkg::*;
#(
  parameter int unsigned TAP_W     = 8,
  parameter int unsigned INIT_TAP  = 1,
  parameter int unsigned MAX_TAP   = 255,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned MOVE_GAP  = 4,
  parameter int unsigned LOAD_HOLD = 2,
  parameter int unsigned QUIESCE   = 1
) (
  input  logic             FAB_CLK,
  input  logic             TX_SYNC_RST,
  input  logic [3:0]       DFI_CS_N,
  input  logic             OUT_EN,
  input  logic             ADJ_REQ,
  input  logic [1:0]       ADJ_CMD,
  input  logic [CNT_W-1:0] ADJ_COUNT,
  output logic             ADJ_BUSY,
  output logic             ADJ_ACK,
  output logic             ADJ_ERR,
  output logic [TAP_W-1:0] TAP_VALUE,
  output logic [3:0]       TX_DATA_0,
  output logic [3:0]       OE_DATA_0,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int unsigned HOLD_W = 8;

  adj_state_e        state_q, state_d;
  adj_cmd_e          cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              err_q, err_d;
  logic              busy_q, ack_q, load_q, move_q, dir_q;
  logic [3:0]        tx_q, oe_q;
  logic              oor_sync;
  logic              start_move;
  logic              at_limit;

  ddr4_bit_sync u_oor_sync (
    .clk_i (FAB_CLK),
    .rst_i (TX_SYNC_RST),
    .d_i   (DELAY_LINE_OUT_OF_RANGE_0),
    .q_o   (oor_sync)
  );

  // Next-state logic; start_move funnels both the first step and each post-gap step
  // through the same count/limit check before a pulse is issued.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    tap_d      = tap_q;
    err_d      = err_q;
    start_move = 1'b0;
    at_limit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ADJ_REQ) begin
          cmd_d  = adj_cmd_e'(ADJ_CMD);
          cnt_d  = ADJ_COUNT;
          err_d  = 1'b0;
          hold_d = '0;
          case (cmd_d)
            ADJ_LOAD: begin
              state_d = S_LOAD;
              tap_d   = TAP_W'(INIT_TAP);
            end
            ADJ_INC, ADJ_DEC: start_move = 1'b1;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (hold_q == HOLD_W'(LOAD_HOLD - 1)) state_d = S_DONE;
        else                                  hold_d  = hold_q + HOLD_W'(1);
      end
      S_MOVE: begin
        state_d = S_GAP;
        hold_d  = '0;
      end
      S_GAP: begin
        if (hold_q == HOLD_W'(MOVE_GAP - 2)) begin
          if (oor_sync) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            start_move = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    at_limit = ((cmd_d == ADJ_INC) && (tap_q == TAP_W'(MAX_TAP))) ||
               ((cmd_d == ADJ_DEC) && (tap_q == '0));

    if (start_move) begin
      if (cnt_d == '0) begin
        state_d = S_DONE;
      end else if (at_limit) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        state_d = S_MOVE;
        cnt_d   = cnt_d - CNT_W'(1);
        tap_d   = (cmd_d == ADJ_INC) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
      end
    end
  end

  // State and registered outputs; strobes are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q <= S_IDLE;
      cmd_q   <= ADJ_LOAD;
      cnt_q   <= '0;
      hold_q  <= '0;
      tap_q   <= TAP_W'(INIT_TAP);
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      dir_q   <= 1'b0;
      tx_q    <= CS_N_IDLE;
      oe_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tap_q   <= tap_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      ack_q   <= (state_d == S_DONE);
      load_q  <= (state_d == S_LOAD);
      move_q  <= (state_d == S_MOVE);
      dir_q   <= (state_d != S_IDLE) && (cmd_d == ADJ_INC);
      tx_q    <= ((QUIESCE != 0) && busy_q) ? CS_N_IDLE : DFI_CS_N;
      oe_q    <= {4{OUT_EN}};
    end
  end

  assign ADJ_BUSY               = busy_q;
  assign ADJ_ACK                = ack_q;
  assign ADJ_ERR                = err_q;
  assign TAP_VALUE              = tap_q;
  assign TX_DATA_0              = tx_q;
  assign OE_DATA_0              = oe_q;
  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr4_ca_lane_tx_ctrl.sv
// Self-checking bench for ddr4_ca_lane_tx_ctrl: directed scenarios followed by
// random adjust requests, checked every cycle against a schedule-based model.
module tb_ddr4_ca_lane_tx_ctrl;

  localparam int TAP_W     = 8;
  localparam int CNT_W     = 7;
  localparam int INIT_TAP  = 1;
  localparam int MAX_TAP   = 255;
  localparam int MOVE_GAP  = 4;
  localparam int LOAD_HOLD = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       cs_n;
  logic             out_en;
  logic             adj_req;
  logic [1:0]       adj_cmd;
  logic [CNT_W-1:0] adj_count;
  logic             adj_busy, adj_ack, adj_err;
  logic [TAP_W-1:0] tap_value;
  logic [3:0]       tx_data, oe_data;
  logic             dl_load, dl_move, dl_dir;
  logic             dl_oor;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_tx, exp_oe;
  int         model_tap;
  logic       model_err;
  bit         force_en;
  logic [3:0] force_cs;
  logic       force_oe;

  always #5 clk = ~clk;

  ddr4_ca_lane_tx_ctrl dut (
    .FAB_CLK                   (clk),
    .TX_SYNC_RST               (rst),
    .DFI_CS_N                  (cs_n),
    .OUT_EN                    (out_en),
    .ADJ_REQ                   (adj_req),
    .ADJ_CMD                   (adj_cmd),
    .ADJ_COUNT                 (adj_count),
    .ADJ_BUSY                  (adj_busy),
    .ADJ_ACK                   (adj_ack),
    .ADJ_ERR                   (adj_err),
    .TAP_VALUE                 (tap_value),
    .TX_DATA_0                 (tx_data),
    .OE_DATA_0                 (oe_data),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE_0 (dl_oor)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Check all outputs at the current negedge, drive next inputs, advance one cycle.
  task automatic cycle_check(input string ph, input logic e_busy, input logic e_ack,
                             input logic e_err, input logic e_load, input logic e_move,
                             input logic e_dir, input int e_tap);
    chk({ph, ".busy"}, 32'(adj_busy), 32'(e_busy));
    chk({ph, ".ack"},  32'(adj_ack),  32'(e_ack));
    chk({ph, ".err"},  32'(adj_err),  32'(e_err));
    chk({ph, ".load"}, 32'(dl_load),  32'(e_load));
    chk({ph, ".move"}, 32'(dl_move),  32'(e_move));
    chk({ph, ".dir"},  32'(dl_dir),   32'(e_dir));
    chk({ph, ".tap"},  32'(tap_value), 32'(e_tap));
    chk({ph, ".tx"},   32'(tx_data),  32'(exp_tx));
    chk({ph, ".oe"},   32'(oe_data),  32'(exp_oe));
    if (force_en) begin
      cs_n   = force_cs;
      out_en = force_oe;
    end else begin
      cs_n   = 4'($urandom);
      out_en = 1'($urandom);
    end
    exp_tx = e_busy ? 4'hF : cs_n;
    exp_oe = {4{out_en}};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_check(input string ph);
    cycle_check(ph, 1'b0, 1'b0, model_err, 1'b0, 1'b0, 1'b0, model_tap);
  endtask

  task automatic do_reset();
    adj_req = 1'b0;
    dl_oor  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    exp_tx    = 4'hF;
    exp_oe    = 4'h0;
    model_tap = INIT_TAP;
    model_err = 1'b0;
    cycle_check("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, INIT_TAP);
  endtask

  // One adjust transaction. oor_j: OOR raised during this cycle index (-1 none);
  // rst_at: reset after checking this cycle index (-1 none); hold: keep ADJ_REQ high.
  task automatic run_adj(input string ph, input int cmd, input int cnt, input int oor_j,
                         input int rst_at, input bit hold);
    int done, pulses, room, sgn, t0, e_tap;
    bit e, is_mv;
    t0 = model_tap; pulses = 0; e = 1'b0; done = 0; sgn = 0;
    is_mv = (cmd == 1) || (cmd == 2);
    if (cmd == 0) begin
      done = LOAD_HOLD;
    end else if (cmd == 3) begin
      e = 1'b1;
    end else begin
      sgn  = (cmd == 1) ? 1 : -1;
      room = (cmd == 1) ? (MAX_TAP - t0) : t0;
      if (cnt != 0 && room == 0) begin
        e = 1'b1;
      end else if (cnt != 0) begin
        for (int k = 1; k <= cnt; k++) begin
          pulses = k;
          done   = k * MOVE_GAP;
          if (oor_j >= 0 && (k * MOVE_GAP - 3) >= oor_j) begin e = 1'b1; break; end
          if (k == cnt) break;
          if (k == room) begin e = 1'b1; break; end
        end
      end
    end

    adj_cmd   = 2'(cmd);
    adj_count = CNT_W'(cnt);
    adj_req   = 1'b1;
    idle_check({ph, ".idle"});
    if (!hold) adj_req = 1'b0;

    for (int i = 0; i <= done; i++) begin
      if (i == oor_j) dl_oor = 1'b1;
      if (cmd == 0)  e_tap = INIT_TAP;
      else if (is_mv) e_tap = t0 + sgn * ((i / MOVE_GAP + 1) < pulses ? (i / MOVE_GAP + 1) : pulses);
      else           e_tap = t0;
      cycle_check($sformatf("%s.c%0d", ph, i), 1'b1, 1'(i == done),
                  (i == done) ? e : 1'b0,
                  1'((cmd == 0) && (i < LOAD_HOLD)),
                  1'(is_mv && (i < pulses * MOVE_GAP) && (i % MOVE_GAP == 0)),
                  1'(cmd == 1), e_tap);
      if (i == rst_at) begin
        do_reset();
        return;
      end
    end
    dl_oor    = 1'b0;
    model_err = e;
    if (cmd == 0)  model_tap = INIT_TAP;
    else if (is_mv) model_tap = t0 + sgn * pulses;
  endtask

  initial begin
    int rcmd, rcnt, roor, rrst;
    rst = 1'b1; cs_n = 4'hF; out_en = 1'b0; adj_req = 1'b0;
    adj_cmd = 2'b00; adj_count = '0; dl_oor = 1'b0; force_en = 1'b0;
    force_cs = 4'h0; force_oe = 1'b0;
    exp_tx = 4'hF; exp_oe = 4'h0; model_tap = INIT_TAP; model_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Datapath: one-cycle latency of CS_N and OE
    force_en = 1'b1; force_cs = 4'b1110; force_oe = 1'b1;
    idle_check("dp0");
    idle_check("dp1");
    force_en = 1'b0;

    // LOAD from tap 40
    run_adj("inc39", 1, 39, -1, -1, 1'b0);
    run_adj("load", 0, 0, -1, -1, 1'b0);

    // INC 3 from tap 1
    run_adj("inc3", 1, 3, -1, -1, 1'b0);

    // DEC 5 from tap 2 hits zero, with CS_N driven low while busy
    run_adj("dec2", 2, 2, -1, -1, 1'b0);
    force_en = 1'b1; force_cs = 4'h0; force_oe = 1'b1;
    run_adj("dec5", 2, 5, -1, -1, 1'b0);
    force_en = 1'b0;

    // INC 4 with OOR raised after second pulse
    run_adj("load2", 0, 0, -1, -1, 1'b0);
    run_adj("oor", 1, 4, MOVE_GAP, -1, 1'b0);

    // Reserved command and zero count
    run_adj("rsv", 3, 5, -1, -1, 1'b0);
    run_adj("inc0", 1, 0, -1, -1, 1'b0);

    // Upper limit: reach MAX_TAP exactly, then one more step errors immediately
    run_adj("load3", 0, 0, -1, -1, 1'b0);
    run_adj("incA", 1, 127, -1, -1, 1'b0);
    run_adj("incB", 1, 127, -1, -1, 1'b0);
    run_adj("incmax", 1, 1, -1, -1, 1'b0);

    // Held request re-accepted only from IDLE, then reset mid-MOVE
    run_adj("hold1", 2, 2, -1, -1, 1'b1);
    run_adj("hold2", 1, 3, -1, MOVE_GAP, 1'b1);
    idle_check("post_rst");

    for (int n = 0; n < 40; n++) begin
      rcmd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 2));
      rcnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
      roor = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      rrst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_adj($sformatf("rnd%0d", n), rcmd, rcnt, roor, rrst, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_check("rnd_idle");
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
